// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bus: pipeline-side hazard sources in, stage enables/flushes out.
// master = pipeline datapath side, slave = hazard controller.
interface pipeline_hazard_ctrl_if;
    logic [4:0]  ID_rs;
    logic [4:0]  ID_rt;
    logic        ID_UseRs;
    logic        ID_UseRt;
    logic [4:0]  EXE_Dst;
    logic        EXE_ReadMem;
    logic        EXE_DivStart;
    logic        EXE_BranchTaken;
    logic        MEM_MemReq;
    logic        MEM_DataOk;
    logic        MEM_ExcValid;
    logic        IF_PCWr;
    logic        IF_IDWr;
    logic        ID_EXEWr;
    logic        EXE_MEMWr;
    logic        MEM_WBWr;
    logic        IFID_Flush;
    logic        IDEXE_Flush;
    logic        EXEMEM_Flush;
    logic        MEMWB_Flush;
    logic        EXE_DivBusy;
    logic        EXE_DivAbort;
    logic [31:0] StallCycles;

    modport master (
        output ID_rs, ID_rt, ID_UseRs, ID_UseRt, EXE_Dst, EXE_ReadMem, EXE_DivStart,
               EXE_BranchTaken, MEM_MemReq, MEM_DataOk, MEM_ExcValid,
        input  IF_PCWr, IF_IDWr, ID_EXEWr, EXE_MEMWr, MEM_WBWr, IFID_Flush, IDEXE_Flush,
               EXEMEM_Flush, MEMWB_Flush, EXE_DivBusy, EXE_DivAbort, StallCycles
    );

    modport slave (
        input  ID_rs, ID_rt, ID_UseRs, ID_UseRt, EXE_Dst, EXE_ReadMem, EXE_DivStart,
               EXE_BranchTaken, MEM_MemReq, MEM_DataOk, MEM_ExcValid,
        output IF_PCWr, IF_IDWr, ID_EXEWr, EXE_MEMWr, MEM_WBWr, IFID_Flush, IDEXE_Flush,
               EXEMEM_Flush, MEMWB_Flush, EXE_DivBusy, EXE_DivAbort, StallCycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Priority: exception > mem wait > divide > load-use > branch.
module pipeline_hazard_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {IDLE, DIV_BUSY, MEM_WAIT, EXC_FLUSH} state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_t           state, state_nxt, eff;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             div_ret, div_ret_nxt;   // a divide is parked behind a mem wait
    logic             load_use, mem_wait;

    assign mem_wait = hz.MEM_MemReq & ~hz.MEM_DataOk;
    assign load_use = hz.EXE_ReadMem & (hz.EXE_Dst != 5'd0) &
                      ((hz.ID_UseRs & (hz.ID_rs == hz.EXE_Dst)) |
                       (hz.ID_UseRt & (hz.ID_rt == hz.EXE_Dst)));

    // Next-state and stage control, highest-priority event first
    always_comb begin
        hz.IF_PCWr      = 1'b1;
        hz.IF_IDWr      = 1'b1;
        hz.ID_EXEWr     = 1'b1;
        hz.EXE_MEMWr    = 1'b1;
        hz.MEM_WBWr     = 1'b1;
        hz.IFID_Flush   = 1'b0;
        hz.IDEXE_Flush  = 1'b0;
        hz.EXEMEM_Flush = 1'b0;
        hz.MEMWB_Flush  = 1'b0;
        hz.EXE_DivBusy  = 1'b0;
        hz.EXE_DivAbort = 1'b0;
        state_nxt       = state;
        cnt_nxt         = cnt;
        div_ret_nxt     = div_ret;
        // Leaving MEM_WAIT resumes whatever was frozen underneath it
        eff = state;
        if (state == MEM_WAIT) eff = div_ret ? DIV_BUSY : IDLE;

        if (rst) begin
            hz.IF_PCWr   = 1'b0;
            hz.IF_IDWr   = 1'b0;
            hz.ID_EXEWr  = 1'b0;
            hz.EXE_MEMWr = 1'b0;
            hz.MEM_WBWr  = 1'b0;
            state_nxt    = IDLE;
            cnt_nxt      = '0;
            div_ret_nxt  = 1'b0;
        end else if (hz.MEM_ExcValid) begin
            // All Wr stay 1 so the PC loads the handler address
            hz.IFID_Flush   = 1'b1;
            hz.IDEXE_Flush  = 1'b1;
            hz.EXEMEM_Flush = 1'b1;
            state_nxt       = EXC_FLUSH;
            div_ret_nxt     = 1'b0;
            if (state == DIV_BUSY || div_ret) begin
                hz.EXE_DivAbort = 1'b1;
                cnt_nxt         = '0;
            end
        end else if (state == EXC_FLUSH) begin
            // Drop the fetch that was in flight when the handler PC loaded
            hz.IFID_Flush = 1'b1;
            state_nxt     = IDLE;
        end else if (mem_wait) begin
            // Freeze everything upstream of MEM; the divide countdown holds too
            hz.IF_PCWr     = 1'b0;
            hz.IF_IDWr     = 1'b0;
            hz.ID_EXEWr    = 1'b0;
            hz.EXE_MEMWr   = 1'b0;
            hz.MEMWB_Flush = 1'b1;
            state_nxt      = MEM_WAIT;
            if (eff == DIV_BUSY) begin
                hz.EXE_DivBusy = 1'b1;
                div_ret_nxt    = 1'b1;
            end
        end else if (eff == DIV_BUSY) begin
            hz.EXE_DivBusy = 1'b1;
            div_ret_nxt    = 1'b0;
            if (cnt != '0) begin
                hz.IF_PCWr      = 1'b0;
                hz.IF_IDWr      = 1'b0;
                hz.ID_EXEWr     = 1'b0;
                hz.EXEMEM_Flush = 1'b1;
                cnt_nxt         = cnt - CNT_W'(1);
                state_nxt       = DIV_BUSY;
            end else begin
                // Release cycle: divide result advances, EXE_DivStart here is the same instr
                state_nxt = IDLE;
            end
        end else begin
            state_nxt = IDLE;
            if (hz.EXE_DivStart) begin
                hz.IF_PCWr      = 1'b0;
                hz.IF_IDWr      = 1'b0;
                hz.ID_EXEWr     = 1'b0;
                hz.EXEMEM_Flush = 1'b1;
                hz.EXE_DivBusy  = 1'b1;
                cnt_nxt         = CNT_LOAD;
                state_nxt       = DIV_BUSY;
            end else if (load_use) begin
                hz.IF_PCWr     = 1'b0;
                hz.IF_IDWr     = 1'b0;
                hz.IDEXE_Flush = 1'b1;
            end else if (hz.EXE_BranchTaken) begin
                hz.IFID_Flush = 1'b1;
            end
        end
    end

    // State, divide countdown and saturating stall counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            div_ret        <= 1'b0;
            hz.StallCycles <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            div_ret <= div_ret_nxt;
            if (!hz.IF_PCWr && hz.StallCycles != 32'hFFFF_FFFF)
                hz.StallCycles <= hz.StallCycles + 32'd1;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: stimulus pushes expected outputs into a
// queue, a negedge monitor pops and compares against the DUT.
module tb_pipeline_hazard_ctrl;
    logic clk;
    logic rst;

    pipeline_hazard_ctrl_if hif();

    pipeline_hazard_ctrl #(.DIV_CYCLES(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif)
    );

    // Output vector: PCWr IFIDWr IDEXEWr EXEMEMWr MEMWBWr | IFIDF IDEXEF EXEMEMF MEMWBF | busy abort
    localparam logic [10:0] RSTV = 11'b00000_0000_00;
    localparam logic [10:0] DEF  = 11'b11111_0000_00;
    localparam logic [10:0] LU   = 11'b00111_0100_00;
    localparam logic [10:0] DIVS = 11'b00011_0010_10;
    localparam logic [10:0] DIVR = 11'b11111_0000_10;
    localparam logic [10:0] MW   = 11'b00001_0001_00;
    localparam logic [10:0] MWB  = 11'b00001_0001_10;
    localparam logic [10:0] EXCA = 11'b11111_1110_01;
    localparam logic [10:0] EXF  = 11'b11111_1000_00;
    localparam logic [10:0] BR   = 11'b11111_1000_00;

    typedef struct {
        string       nm;
        logic [10:0] exp;
        logic [31:0] cnt;
    } ent_t;

    ent_t        q[$];
    ent_t        me;
    logic [10:0] act;
    int          n_run  = 0;
    int          n_fail = 0;
    logic [31:0] model_cnt = 0;

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Monitor: the controller presents a response every cycle; compare mid-cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            me  = q.pop_front();
            act = {hif.IF_PCWr, hif.IF_IDWr, hif.ID_EXEWr, hif.EXE_MEMWr, hif.MEM_WBWr,
                   hif.IFID_Flush, hif.IDEXE_Flush, hif.EXEMEM_Flush, hif.MEMWB_Flush,
                   hif.EXE_DivBusy, hif.EXE_DivAbort};
            n_run++;
            if (act !== me.exp) begin
                n_fail++;
                $display("FAIL %s outs: got %b want %b", me.nm, act, me.exp);
            end
            n_run++;
            if (hif.StallCycles !== me.cnt) begin
                n_fail++;
                $display("FAIL %s stall_cnt: got %0d want %0d", me.nm, hif.StallCycles, me.cnt);
            end
        end
    end

    task automatic step(input string nm, input logic [10:0] exp);
        ent_t e;
        e.nm  = nm;
        e.exp = exp;
        e.cnt = model_cnt;
        q.push_back(e);
        if (!rst && !exp[10]) model_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        hif.ID_rs = 5'd0;  hif.ID_rt = 5'd0;
        hif.ID_UseRs = 1'b0; hif.ID_UseRt = 1'b0;
        hif.EXE_Dst = 5'd0; hif.EXE_ReadMem = 1'b0;
        hif.EXE_DivStart = 1'b0; hif.EXE_BranchTaken = 1'b0;
        hif.MEM_MemReq = 1'b0; hif.MEM_DataOk = 1'b0; hif.MEM_ExcValid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clr();
        model_cnt = 0;
        step("reset", RSTV);
        rst = 1'b0;
        step("idle", DEF);

        // Load-use: lw $2 in EXE, add $3,$2,$4 in ID
        hif.EXE_ReadMem = 1'b1; hif.EXE_Dst = 5'd2;
        hif.ID_rs = 5'd2; hif.ID_rt = 5'd4; hif.ID_UseRs = 1'b1; hif.ID_UseRt = 1'b1;
        step("lu_rs", LU);
        hif.EXE_Dst = 5'd0; hif.ID_rs = 5'd0;
        step("lu_dst0", DEF);
        hif.EXE_Dst = 5'd7; hif.ID_rs = 5'd3; hif.ID_rt = 5'd7;
        step("lu_rt", LU);
        hif.ID_UseRt = 1'b0;
        step("lu_rt_unused", DEF);

        // Branch vs load-use
        hif.ID_UseRt = 1'b1; hif.EXE_BranchTaken = 1'b1;
        step("br_with_lu", LU);
        clr(); hif.EXE_BranchTaken = 1'b1;
        step("br_alone", BR);
        clr();
        step("post_br", DEF);

        // Divide: 32 stall cycles, busy 33, no restart on release
        hif.EXE_DivStart = 1'b1;
        step("div_start", DIVS);
        for (int i = 0; i < 31; i++) step("div_stall", DIVS);
        step("div_release", DIVR);
        hif.EXE_DivStart = 1'b0;
        step("div_norestart", DEF);

        // Mem wait: 5 frozen cycles then release on DataOk
        hif.MEM_MemReq = 1'b1;
        for (int i = 0; i < 5; i++) step("mem_wait", MW);
        hif.MEM_DataOk = 1'b1;
        step("mem_release", DEF);
        clr();
        step("mem_after", DEF);

        // Exception at divide countdown 10
        hif.EXE_DivStart = 1'b1;
        step("div2_start", DIVS);
        for (int i = 0; i < 21; i++) step("div2_stall", DIVS);
        hif.MEM_ExcValid = 1'b1;
        step("exc_abort", EXCA);
        clr();
        step("exc_flush", EXF);
        step("exc_idle", DEF);

        // Mem wait arriving mid-divide freezes the countdown
        hif.EXE_DivStart = 1'b1;
        step("div3_start", DIVS);
        for (int i = 0; i < 4; i++) step("div3_stall", DIVS);
        hif.MEM_MemReq = 1'b1;
        for (int i = 0; i < 3; i++) step("div3_memwait", MWB);
        hif.MEM_DataOk = 1'b1;
        step("div3_memrel", DIVS);
        hif.MEM_MemReq = 1'b0; hif.MEM_DataOk = 1'b0;
        for (int i = 0; i < 26; i++) step("div3_resume", DIVS);
        step("div3_release", DIVR);
        hif.EXE_DivStart = 1'b0;
        step("div3_done", DEF);

        // Reset mid mem-wait
        hif.MEM_MemReq = 1'b1;
        step("rw_wait0", MW);
        step("rw_wait1", MW);
        rst = 1'b1;
        model_cnt = 0;
        step("rst_midwait", RSTV);
        rst = 1'b0;
        clr();
        step("post_rst", DEF);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
